// File: rtl/l15_simple_transducer.sv
// -----------------------------------------------------------------------------
// l15_simple_transducer
//
// Core-side initiator for the L1.5 transducer interface. A cache-less master
// (accelerator or test core) hands over one simple 64-bit load or store at a
// time. The block issues it as an L1.5 request and waits for the matching
// return. It then hands the formatted result back to the master. Returns the
// master never asked for (invalidations, evictions, interrupts) are acked and
// dropped, because the master holds no L1 state that they could refer to.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   mem_req_*                  master request channel (val/rdy handshake)
//                                rw: 1 = store, 0 = load
//                                size: 0..3 = 1B..8B
//                                wdata: store data, right-justified
//   mem_resp_*                 master response channel (val/rdy handshake)
//                                rdata: right-justified, zero-extended
//                                err: 2'b11 = rejected locally
//   transducer_l15_*           request fields toward the L1.5
//                                val is held with its fields until ack
//   l15_transducer_ack         L1.5 accepted the request
//   l15_transducer_header_ack  unused
//   l15_transducer_val/...     L1.5 return (returntype, error, data_0/1)
//   transducer_l15_req_ack     return consumed (combinational)
// -----------------------------------------------------------------------------
module l15_simple_transducer #(
  parameter logic THREADID = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,

  // Master request
  input  logic        mem_req_val,
  output logic        mem_req_rdy,
  input  logic        mem_req_rw,
  input  logic        mem_req_nc,
  input  logic [2:0]  mem_req_size,
  input  logic [39:0] mem_req_addr,
  input  logic [63:0] mem_req_wdata,

  // Master response
  output logic        mem_resp_val,
  input  logic        mem_resp_rdy,
  output logic [63:0] mem_resp_rdata,
  output logic [1:0]  mem_resp_err,

  // Request to L1.5
  output logic        transducer_l15_val,
  output logic [4:0]  transducer_l15_rqtype,
  output logic        transducer_l15_nc,
  output logic [2:0]  transducer_l15_size,
  output logic        transducer_l15_threadid,
  output logic [39:0] transducer_l15_address,
  output logic [63:0] transducer_l15_data,
  output logic [3:0]  transducer_l15_amo_op,
  output logic        transducer_l15_prefetch,
  output logic        transducer_l15_invalidate_cacheline,
  output logic        transducer_l15_blockstore,
  output logic        transducer_l15_blockinitstore,
  output logic [1:0]  transducer_l15_l1rplway,
  output logic [63:0] transducer_l15_data_next_entry,
  output logic [32:0] transducer_l15_csm_data,
  input  logic        l15_transducer_ack,
  input  logic        l15_transducer_header_ack,

  // Return from L1.5
  input  logic        l15_transducer_val,
  input  logic [3:0]  l15_transducer_returntype,
  input  logic [1:0]  l15_transducer_error,
  input  logic [63:0] l15_transducer_data_0,
  input  logic [63:0] l15_transducer_data_1,
  output logic        transducer_l15_req_ack
);

  localparam logic [4:0] LOAD_RQ  = 5'b00000;
  localparam logic [4:0] STORE_RQ = 5'b00001;
  localparam logic [3:0] LOAD_RET = 4'b0000;
  localparam logic [3:0] ST_ACK   = 4'b0100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } state_e;

  state_e state_q, state_d;

  // Captured request.
  logic        req_rw_q;
  logic        req_nc_q;
  logic [2:0]  req_size_q;
  logic [39:0] req_addr_q;
  logic [63:0] req_data_q;

  // Captured response.
  logic [63:0] resp_rdata_q;
  logic [1:0]  resp_err_q;

  logic req_fire;
  logic misaligned;
  logic ret_match;

  // Header ack carries no information this block needs.
  logic unused_header_ack;
  assign unused_header_ack = l15_transducer_header_ack;

  // ---------------------------------------------------------------------------
  // Data formatting helpers
  // ---------------------------------------------------------------------------

  // The L1.5 expects store data replicated across the whole doubleword.
  function automatic logic [63:0] replicate_store(input logic [2:0]  size,
                                                  input logic [63:0] d);
    case (size)
      3'd0:    replicate_store = {8{d[7:0]}};
      3'd1:    replicate_store = {4{d[15:0]}};
      3'd2:    replicate_store = {2{d[31:0]}};
      default: replicate_store = d;
    endcase
  endfunction

  // Return data is big-endian: byte offset 0 is w[63:56]. Shifting the word
  // left by the offset puts the addressed bytes at the top. The top bytes
  // are then taken for the access size.
  function automatic logic [63:0] format_load(input logic [2:0]  size,
                                              input logic [39:0] addr,
                                              input logic [63:0] d0,
                                              input logic [63:0] d1);
    logic [63:0] w;
    logic [63:0] aligned;
    w       = addr[3] ? d1 : d0;
    aligned = w << {addr[2:0], 3'b000};
    case (size)
      3'd0:    format_load = {56'b0, aligned[63:56]};
      3'd1:    format_load = {48'b0, aligned[63:48]};
      3'd2:    format_load = {32'b0, aligned[63:32]};
      default: format_load = aligned;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  assign req_fire  = (state_q == ST_IDLE) && mem_req_val;
  assign ret_match = (state_q == ST_WAIT) && l15_transducer_val &&
                     (l15_transducer_returntype == (req_rw_q ? ST_ACK : LOAD_RET));

  // NOTE: every variable assigned in a combinational block gets a default
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    misaligned = 1'b0;
    case (mem_req_size)
      3'd0:    misaligned = 1'b0;
      3'd1:    misaligned = mem_req_addr[0];
      3'd2:    misaligned = |mem_req_addr[1:0];
      3'd3:    misaligned = |mem_req_addr[2:0];
      default: misaligned = 1'b1;  // illegal size
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples the values from before the edge, whatever the statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mem_req_val)        state_d = misaligned ? ST_RESP : ST_REQ;
      ST_REQ:  if (l15_transducer_ack) state_d = ST_WAIT;
      ST_WAIT: if (ret_match)          state_d = ST_RESP;
      ST_RESP: if (mem_resp_rdy)       state_d = ST_IDLE;
      default:                         state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // Reset gates the handshakes so that all of them read 0 while rst_n is low.
  // Returns are stalled only in RESP, because the single response register
  // is still occupied there.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_req_rdy            = 1'b0;
    mem_resp_val           = 1'b0;
    transducer_l15_val     = 1'b0;
    transducer_l15_req_ack = 1'b0;
    if (rst_n) begin
      case (state_q)
        ST_IDLE: mem_req_rdy        = 1'b1;
        ST_REQ:  transducer_l15_val = 1'b1;
        ST_RESP: mem_resp_val       = 1'b1;
        default: ;
      endcase
      transducer_l15_req_ack = l15_transducer_val && (state_q != ST_RESP);
    end
  end

  // ---------------------------------------------------------------------------
  // Request / response capture
  // ---------------------------------------------------------------------------
  // NOTE: the datapath registers are reset as well. They drive outputs
  // directly, and those outputs must read 0 out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_rw_q     <= 1'b0;
      req_nc_q     <= 1'b0;
      req_size_q   <= 3'd0;
      req_addr_q   <= 40'd0;
      req_data_q   <= 64'd0;
      resp_rdata_q <= 64'd0;
      resp_err_q   <= 2'b00;
    end else if (req_fire) begin
      req_rw_q     <= mem_req_rw;
      req_nc_q     <= mem_req_nc;
      req_size_q   <= mem_req_size;
      req_addr_q   <= mem_req_addr;
      req_data_q   <= replicate_store(mem_req_size, mem_req_wdata);
      // A locally rejected request goes straight to RESP with this result.
      resp_rdata_q <= 64'd0;
      resp_err_q   <= misaligned ? 2'b11 : 2'b00;
    end else if (ret_match) begin
      resp_rdata_q <= req_rw_q ? 64'd0
                               : format_load(req_size_q, req_addr_q,
                                             l15_transducer_data_0,
                                             l15_transducer_data_1);
      resp_err_q   <= l15_transducer_error;
    end
  end

  // ---------------------------------------------------------------------------
  // Output fields
  // ---------------------------------------------------------------------------
  assign transducer_l15_rqtype   = req_rw_q ? STORE_RQ : LOAD_RQ;
  assign transducer_l15_nc       = req_nc_q;
  assign transducer_l15_size     = req_size_q;
  assign transducer_l15_threadid = THREADID;
  assign transducer_l15_address  = req_addr_q;
  assign transducer_l15_data     = req_data_q;

  assign transducer_l15_amo_op               = 4'd0;
  assign transducer_l15_prefetch             = 1'b0;
  assign transducer_l15_invalidate_cacheline = 1'b0;
  assign transducer_l15_blockstore           = 1'b0;
  assign transducer_l15_blockinitstore       = 1'b0;
  assign transducer_l15_l1rplway             = 2'd0;
  assign transducer_l15_data_next_entry      = 64'd0;
  assign transducer_l15_csm_data             = 33'd0;

  assign mem_resp_rdata = resp_rdata_q;
  assign mem_resp_err   = resp_err_q;

endmodule

// File: tb/tb_l15_simple_transducer.sv
// -----------------------------------------------------------------------------
// tb_l15_simple_transducer
//
// Directed bench for l15_simple_transducer. A table of single transactions
// (request, L1.5 return, expected request fields and response) is applied in
// a loop. Hand-written sequences cover the multi-cycle corner cases:
// unsolicited returns, response back-pressure, ack colliding with a return,
// and reset in the middle of a transaction. Inputs change on the falling
// edge, and outputs are sampled 1 ns later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_l15_simple_transducer;

  logic        clk;
  logic        rst_n;
  logic        mem_req_val, mem_req_rdy, mem_req_rw, mem_req_nc;
  logic [2:0]  mem_req_size;
  logic [39:0] mem_req_addr;
  logic [63:0] mem_req_wdata;
  logic        mem_resp_val, mem_resp_rdy;
  logic [63:0] mem_resp_rdata;
  logic [1:0]  mem_resp_err;
  logic        l15_val;
  logic [4:0]  l15_rqtype;
  logic        l15_nc;
  logic [2:0]  l15_size;
  logic        l15_threadid;
  logic [39:0] l15_address;
  logic [63:0] l15_data;
  logic [3:0]  l15_amo_op;
  logic        l15_prefetch, l15_inv_line, l15_blockstore, l15_blockinitstore;
  logic [1:0]  l15_l1rplway;
  logic [63:0] l15_data_next_entry;
  logic [32:0] l15_csm_data;
  logic        ack, header_ack;
  logic        ret_val;
  logic [3:0]  ret_type;
  logic [1:0]  ret_error;
  logic [63:0] ret_data_0, ret_data_1;
  logic        req_ack;

  int errors = 0;
  int checks = 0;

  l15_simple_transducer #(.THREADID(1'b0)) dut (
    .clk                                 (clk),
    .rst_n                               (rst_n),
    .mem_req_val                         (mem_req_val),
    .mem_req_rdy                         (mem_req_rdy),
    .mem_req_rw                          (mem_req_rw),
    .mem_req_nc                          (mem_req_nc),
    .mem_req_size                        (mem_req_size),
    .mem_req_addr                        (mem_req_addr),
    .mem_req_wdata                       (mem_req_wdata),
    .mem_resp_val                        (mem_resp_val),
    .mem_resp_rdy                        (mem_resp_rdy),
    .mem_resp_rdata                      (mem_resp_rdata),
    .mem_resp_err                        (mem_resp_err),
    .transducer_l15_val                  (l15_val),
    .transducer_l15_rqtype               (l15_rqtype),
    .transducer_l15_nc                   (l15_nc),
    .transducer_l15_size                 (l15_size),
    .transducer_l15_threadid             (l15_threadid),
    .transducer_l15_address              (l15_address),
    .transducer_l15_data                 (l15_data),
    .transducer_l15_amo_op               (l15_amo_op),
    .transducer_l15_prefetch             (l15_prefetch),
    .transducer_l15_invalidate_cacheline (l15_inv_line),
    .transducer_l15_blockstore           (l15_blockstore),
    .transducer_l15_blockinitstore       (l15_blockinitstore),
    .transducer_l15_l1rplway             (l15_l1rplway),
    .transducer_l15_data_next_entry      (l15_data_next_entry),
    .transducer_l15_csm_data             (l15_csm_data),
    .l15_transducer_ack                  (ack),
    .l15_transducer_header_ack           (header_ack),
    .l15_transducer_val                  (ret_val),
    .l15_transducer_returntype           (ret_type),
    .l15_transducer_error                (ret_error),
    .l15_transducer_data_0               (ret_data_0),
    .l15_transducer_data_1               (ret_data_1),
    .transducer_l15_req_ack              (req_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rw;
    logic [2:0]  size;
    logic [39:0] addr;
    logic [63:0] wdata;
    logic [3:0]  ret_type;
    logic [1:0]  ret_error;
    logic [63:0] d0;
    logic [63:0] d1;
    logic        reject;
    logic [63:0] exp_l15_data;
    logic [63:0] exp_rdata;
    logic [1:0]  exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic vec_t mk(string name, logic rw, logic [2:0] size, logic [39:0] addr,
                              logic [63:0] wdata, logic [3:0] rt, logic [1:0] re,
                              logic [63:0] d0, logic [63:0] d1, logic reject,
                              logic [63:0] exp_data, logic [63:0] exp_rdata,
                              logic [1:0] exp_err);
    vec_t v;
    v.name = name; v.rw = rw; v.size = size; v.addr = addr; v.wdata = wdata;
    v.ret_type = rt; v.ret_error = re; v.d0 = d0; v.d1 = d1; v.reject = reject;
    v.exp_l15_data = exp_data; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  // Presents a request in IDLE, then scrambles the inputs so the checks
  // below can only pass from captured values.
  task automatic issue(input logic rw, input logic [2:0] size, input logic [39:0] addr,
                       input logic [63:0] wdata);
    tick();
    mem_req_val = 1'b1; mem_req_rw = rw; mem_req_nc = 1'b1;
    mem_req_size = size; mem_req_addr = addr; mem_req_wdata = wdata;
    #1 check("req_rdy_idle", 64'(mem_req_rdy), 64'd1);
    tick();
    mem_req_val = 1'b0; mem_req_rw = ~rw; mem_req_nc = 1'b0;
    mem_req_size = 3'd7; mem_req_addr = '1; mem_req_wdata = '1;
    #1 check("req_rdy_busy", 64'(mem_req_rdy), 64'd0);
  endtask

  // Completes the response handshake and checks the return to IDLE.
  task automatic finish_resp(input string name);
    mem_resp_rdy = 1'b1;
    tick();
    mem_resp_rdy = 1'b0;
    #1;
    check({name, "_resp_val_drop"}, 64'(mem_resp_val), 64'd0);
    check({name, "_rdy_after"}, 64'(mem_req_rdy), 64'd1);
  endtask

  task automatic run_vec(input vec_t v);
    issue(v.rw, v.size, v.addr, v.wdata);
    if (v.reject) begin
      check({v.name, "_no_l15_val"}, 64'(l15_val), 64'd0);
      check({v.name, "_resp_val"}, 64'(mem_resp_val), 64'd1);
      check({v.name, "_err"}, 64'(mem_resp_err), 64'(2'b11));
      check({v.name, "_rdata"}, mem_resp_rdata, 64'd0);
    end else begin
      check({v.name, "_l15_val"}, 64'(l15_val), 64'd1);
      check({v.name, "_rqtype"}, 64'(l15_rqtype), v.rw ? 64'd1 : 64'd0);
      check({v.name, "_size"}, 64'(l15_size), 64'(v.size));
      check({v.name, "_addr"}, 64'(l15_address), 64'(v.addr));
      check({v.name, "_data"}, l15_data, v.exp_l15_data);
      check({v.name, "_nc"}, 64'(l15_nc), 64'd1);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      #1;
      check({v.name, "_val_drop"}, 64'(l15_val), 64'd0);
      ret_val = 1'b1; ret_type = v.ret_type; ret_error = v.ret_error;
      ret_data_0 = v.d0; ret_data_1 = v.d1;
      #1 check({v.name, "_req_ack"}, 64'(req_ack), 64'd1);
      tick();
      ret_val = 1'b0; ret_data_0 = '0; ret_data_1 = '0; ret_error = 2'b00;
      #1;
      check({v.name, "_resp_val"}, 64'(mem_resp_val), 64'd1);
      check({v.name, "_rdata"}, mem_resp_rdata, v.exp_rdata);
      check({v.name, "_err"}, 64'(mem_resp_err), 64'(v.exp_err));
    end
    finish_resp(v.name);
  endtask

  initial begin
    rst_n = 1'b0;
    mem_req_val = 1'b0; mem_req_rw = 1'b0; mem_req_nc = 1'b0; mem_req_size = 3'd0;
    mem_req_addr = '0; mem_req_wdata = '0; mem_resp_rdy = 1'b0;
    ack = 1'b0; header_ack = 1'b0; ret_val = 1'b0; ret_type = 4'd0; ret_error = 2'd0;
    ret_data_0 = '0; ret_data_1 = '0;

    //        name       rw  sz  addr               wdata                  rt     re     d0                     d1                     rej   l15_data               rdata                  err
    vecs.push_back(mk("ld8",   0, 3, 40'h10_0000_0008, 64'h0,                 4'h0, 2'b00, 64'hDEADBEEF_DEADBEEF, 64'h01234567_89ABCDEF, 0, 64'h0,                 64'h01234567_89ABCDEF, 2'b00));
    vecs.push_back(mk("st1",   1, 0, 40'h00_0000_0003, 64'h12345678_9ABCDEA5, 4'h4, 2'b00, 64'hFFFF, 64'hFFFF,                       0, 64'hA5A5A5A5_A5A5A5A5, 64'h0,                 2'b00));
    vecs.push_back(mk("ld2o6", 0, 1, 40'h00_0000_0006, 64'h0,                 4'h0, 2'b00, 64'h11223344_55667788, 64'hAAAAAAAA_AAAAAAAA, 0, 64'h0,                 64'h7788,              2'b00));
    vecs.push_back(mk("ld4mis",0, 2, 40'h00_0000_0002, 64'h0,                 4'h0, 2'b00, 64'h0, 64'h0,                             1, 64'h0,                 64'h0,                 2'b11));
    vecs.push_back(mk("ld4hi", 0, 2, 40'h00_0000_000C, 64'h0,                 4'h0, 2'b10, 64'h0, 64'h00112233_44556677,             0, 64'h0,                 64'h44556677,          2'b10));
    vecs.push_back(mk("st2",   1, 1, 40'h00_0000_0002, 64'hFFFF0000_0000BEEF, 4'h4, 2'b00, 64'h0, 64'h0,                             0, 64'hBEEFBEEF_BEEFBEEF, 64'h0,                 2'b00));
    vecs.push_back(mk("st4",   1, 2, 40'h00_0000_0004, 64'h11111111_CAFEF00D, 4'h4, 2'b01, 64'h0, 64'h0,                             0, 64'hCAFEF00D_CAFEF00D, 64'h0,                 2'b01));
    vecs.push_back(mk("st8",   1, 3, 40'hFF_0000_0008, 64'h01020304_05060708, 4'h4, 2'b00, 64'h0, 64'h0,                             0, 64'h01020304_05060708, 64'h0,                 2'b00));
    vecs.push_back(mk("ld1o0", 0, 0, 40'h00_0000_0010, 64'h0,                 4'h0, 2'b00, 64'hAB112233_44556677, 64'h0,             0, 64'h0,                 64'hAB,                2'b00));
    vecs.push_back(mk("ld1o7", 0, 0, 40'h00_0000_000F, 64'h0,                 4'h0, 2'b00, 64'h0, 64'h00000000_00000099,             0, 64'h0,                 64'h99,                2'b00));
    vecs.push_back(mk("sz4bad",0, 4, 40'h00_0000_0000, 64'h0,                 4'h0, 2'b00, 64'h0, 64'h0,                             1, 64'h0,                 64'h0,                 2'b11));
    vecs.push_back(mk("ld8mis",0, 3, 40'h00_0000_0004, 64'h0,                 4'h0, 2'b00, 64'h0, 64'h0,                             1, 64'h0,                 64'h0,                 2'b11));
    vecs.push_back(mk("st2odd",1, 1, 40'h00_0000_0001, 64'h1234,              4'h4, 2'b00, 64'h0, 64'h0,                             1, 64'h0,                 64'h0,                 2'b11));

    // Reset state.
    tick(); tick();
    #1;
    check("rst_req_rdy", 64'(mem_req_rdy), 64'd0);
    check("rst_l15_val", 64'(l15_val), 64'd0);
    check("rst_resp_val", 64'(mem_resp_val), 64'd0);
    check("rst_l15_data", l15_data, 64'd0);
    check("rst_rqtype", 64'(l15_rqtype), 64'd0);
    check("rst_resp_rdata", mem_resp_rdata, 64'd0);
    rst_n = 1'b1;
    tick();
    #1 check("first_idle_rdy", 64'(mem_req_rdy), 64'd1);

    // Unsolicited return in IDLE is acked immediately.
    ret_val = 1'b1; ret_type = 4'b0011;
    #1 check("idle_unsol_ack", 64'(req_ack), 64'd1);
    tick(); ret_val = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // INV_RET in WAIT, then LOAD_RET: both acked, a single response.
    issue(1'b0, 3'd3, 40'h00_0000_0000, 64'h0);
    ack = 1'b1;
    tick(); ack = 1'b0;
    ret_val = 1'b1; ret_type = 4'b0011; ret_data_0 = 64'h5555_5555_5555_5555;
    #1 check("inv_wait_ack", 64'(req_ack), 64'd1);
    tick();
    ret_type = 4'b0000; ret_data_0 = 64'hFEDCBA98_76543210;
    #1;
    check("inv_no_resp", 64'(mem_resp_val), 64'd0);
    check("load_ret_ack", 64'(req_ack), 64'd1);
    tick(); ret_val = 1'b0; ret_data_0 = '0;
    #1;
    check("inv_seq_resp_val", 64'(mem_resp_val), 64'd1);
    check("inv_seq_rdata", mem_resp_rdata, 64'hFEDCBA98_76543210);
    finish_resp("inv_seq");

    // Back-pressure: INV_RET pending while the response waits for 5 cycles.
    issue(1'b0, 3'd2, 40'h00_0000_0000, 64'h0);
    ack = 1'b1;
    tick(); ack = 1'b0;
    ret_val = 1'b1; ret_type = 4'b0000; ret_data_0 = 64'hCAFEBABE_00000000;
    tick();
    ret_type = 4'b0011; ret_data_0 = '0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_req_ack_low", 64'(req_ack), 64'd0);
      check("bp_resp_hold", {31'd0, mem_resp_val, 32'(mem_resp_rdata)}, {31'd0, 1'b1, 32'hCAFEBABE});
      tick();
    end
    mem_resp_rdy = 1'b1;
    #1 check("bp_ack_in_handshake", 64'(req_ack), 64'd0);
    tick(); mem_resp_rdy = 1'b0;
    #1;
    check("bp_ack_idle", 64'(req_ack), 64'd1);
    check("bp_rdy_idle", 64'(mem_req_rdy), 64'd1);
    tick(); ret_val = 1'b0;

    // Ack and return in the same REQ cycle; the REQ is held one extra cycle first.
    issue(1'b1, 3'd3, 40'h00_0000_0010, 64'h0A0B0C0D_0E0F1011);
    tick();
    #1 check("req_hold_val", 64'(l15_val), 64'd1);
    check("req_hold_data", l15_data, 64'h0A0B0C0D_0E0F1011);
    ack = 1'b1; ret_val = 1'b1; ret_type = 4'b0100;
    #1 check("collide_req_ack", 64'(req_ack), 64'd1);
    tick(); ack = 1'b0; ret_val = 1'b0;
    #1 check("collide_no_resp", 64'(mem_resp_val), 64'd0);
    tick();
    #1 check("collide_still_wait", 64'(mem_resp_val), 64'd0);
    ret_val = 1'b1; ret_type = 4'b0100;
    tick(); ret_val = 1'b0;
    #1 check("collide_resp_val", 64'(mem_resp_val), 64'd1);
    check("collide_rdata", mem_resp_rdata, 64'd0);
    finish_resp("collide");

    // Reset pulsed while in REQ.
    issue(1'b0, 3'd3, 40'h00_0000_0008, 64'h0);
    check("rstreq_val", 64'(l15_val), 64'd1);
    rst_n = 1'b0;
    tick();
    #1;
    check("rstreq_val_drop", 64'(l15_val), 64'd0);
    check("rstreq_rdy_in_rst", 64'(mem_req_rdy), 64'd0);
    rst_n = 1'b1;
    tick();
    #1;
    check("rstreq_rdy_after", 64'(mem_req_rdy), 64'd1);
    check("rstreq_val_after", 64'(l15_val), 64'd0);
    check("rstreq_resp_after", 64'(mem_resp_val), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog: the directed sequence is bounded, but guard against a stuck clock.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
